// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one bit pair per clock through a full-adder cell
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-2:0] ps;
  logic [WIDTH-1:0] ps_full;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             s, cout, last, accept;

  serial_adder_fa u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (c),
    .s    (s),
    .cout (cout)
  );

  // Only WIDTH-1 bits need storing: the final bit goes straight into sum.
  assign ps_full = {s, ps};
  assign last    = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ADD;
        end
      end
      ADD: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        accept    = start;
        state_nxt = start ? ADD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      ps    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ADD);
      done  <= (state_nxt == DONE);
      if (accept) begin
        sa  <= a;
        sb  <= b;
        ps  <= '0;
        c   <= 1'b0;
        cnt <= '0;
      end else if (state == ADD) begin
        sa  <= {1'b0, sa[WIDTH-1:1]};
        sb  <= {1'b0, sb[WIDTH-1:1]};
        ps  <= ps_full[WIDTH-1:1];
        c   <= cout;
        cnt <= cnt + CW'(1);
        if (last) begin
          sum   <= ps_full;
          carry <= cout;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH 8 and 2
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start2;
  logic [7:0] a8, b8, sum8;
  logic [1:0] a2, b2, sum2;
  logic       busy8, done8, carry8;
  logic       busy2, done2, carry2;

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];
  int   cyc = 0;
  int   last8 = -1000, last2 = -1000;
  int   hold8 = 0, hold2 = 0;
  int   checks = 0, errors = 0;
  bit   mon_en = 1'b0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .sum(sum2), .carry(carry2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: a start is taken unless a previous one was taken within the last WIDTH edges.
  always @(posedge clk) begin
    if (rst) begin
      q8.delete(); q2.delete();
      last8 = -1000; last2 = -1000;
      hold8 = 0; hold2 = 0;
    end else begin
      if (start8 && (cyc + 1) >= last8 + 9) begin
        q8.push_back('{val: int'(a8) + int'(b8), due: cyc + 1 + 8});
        last8 = cyc + 1;
      end
      if (start2 && (cyc + 1) >= last2 + 3) begin
        q2.push_back('{val: int'(a2) + int'(b2), due: cyc + 1 + 2});
        last2 = cyc + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      int   got8, got2;
      got8 = int'({carry8, sum8});
      got2 = int'({carry2, sum2});

      checks++;
      if (busy8 !== (cyc >= last8 && cyc < last8 + 8)) begin
        errors++;
        $display("FAIL busy8 cyc=%0d got=%b want=%b", cyc, busy8, (cyc >= last8 && cyc < last8 + 8));
      end
      checks++;
      if (busy8 === 1'b1 && done8 === 1'b1) begin
        errors++;
        $display("FAIL busy_done8 cyc=%0d got both high want exclusive", cyc);
      end
      if (q8.size() > 0 && q8[0].due < cyc) begin
        e = q8.pop_front();
        checks++; errors++;
        $display("FAIL missed_done8 cyc=%0d got none want done at %0d", cyc, e.due);
      end
      if (done8 === 1'b1) begin
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL spurious_done8 cyc=%0d got done=1 want done=0", cyc);
        end else begin
          e = q8.pop_front();
          if (got8 !== e.val || cyc !== e.due) begin
            errors++;
            $display("FAIL result8 cyc=%0d got %0h at %0d want %0h at %0d", cyc, got8, cyc, e.val, e.due);
          end
          hold8 = e.val;
        end
      end else begin
        checks++;
        if (done8 !== 1'b0 || got8 !== hold8) begin
          errors++;
          $display("FAIL hold8 cyc=%0d got done=%b val=%0h want done=0 val=%0h", cyc, done8, got8, hold8);
        end
      end

      checks++;
      if (busy2 !== (cyc >= last2 && cyc < last2 + 2)) begin
        errors++;
        $display("FAIL busy2 cyc=%0d got=%b want=%b", cyc, busy2, (cyc >= last2 && cyc < last2 + 2));
      end
      if (q2.size() > 0 && q2[0].due < cyc) begin
        e = q2.pop_front();
        checks++; errors++;
        $display("FAIL missed_done2 cyc=%0d got none want done at %0d", cyc, e.due);
      end
      if (done2 === 1'b1) begin
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL spurious_done2 cyc=%0d got done=1 want done=0", cyc);
        end else begin
          e = q2.pop_front();
          if (got2 !== e.val || cyc !== e.due) begin
            errors++;
            $display("FAIL result2 cyc=%0d got %0h at %0d want %0h at %0d", cyc, got2, cyc, e.val, e.due);
          end
          hold2 = e.val;
        end
      end else begin
        checks++;
        if (done2 !== 1'b0 || got2 !== hold2) begin
          errors++;
          $display("FAIL hold2 cyc=%0d got done=%b val=%0h want done=0 val=%0h", cyc, done2, got2, hold2);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse8(input logic [7:0] x, input logic [7:0] y);
    a8 = x; b8 = y; start8 = 1'b1;
    tick(1);
    start8 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start8 = 1'b0; start2 = 1'b0;
    a8 = '0; b8 = '0; a2 = '0; b2 = '0;
    tick(3);
    mon_en = 1'b1;
    rst = 1'b0;
    tick(2);

    pulse8(8'h3C, 8'h5A); tick(10);
    pulse8(8'hFF, 8'h01); tick(10);
    pulse8(8'hFF, 8'hFF); tick(10);
    pulse8(8'h00, 8'h00); tick(10);

    pulse8(8'h10, 8'h20);
    tick(2);
    pulse8(8'hAA, 8'h55);
    tick(12);

    a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
    tick(1);
    a8 = 8'h80; b8 = 8'h80;
    tick(9);
    start8 = 1'b0;
    tick(12);

    pulse8(8'h3C, 8'h5A);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    pulse8(8'h01, 8'h01); tick(10);

    for (int i = 0; i < 16; i++) begin
      a2 = 2'(i >> 2); b2 = 2'(i); start2 = 1'b1;
      tick(1);
      start2 = 1'b0;
      tick(3);
    end

    for (int i = 0; i < 400; i++) begin
      start8 = ($urandom_range(0, 2) == 0);
      a8 = 8'($urandom); b8 = 8'($urandom);
      start2 = ($urandom_range(0, 1) == 0);
      a2 = 2'($urandom); b2 = 2'($urandom);
      rst = ($urandom_range(0, 59) == 0);
      tick(1);
    end
    start8 = 1'b0; start2 = 1'b0; rst = 1'b0;

    for (int i = 0; i < 40 && (q8.size() > 0 || q2.size() > 0); i++) tick(1);
    checks++;
    if (q8.size() > 0 || q2.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending want 0/0", q8.size(), q2.size());
    end
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
